// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the pipeline and RAM interface
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_I = 2'd1,
        SERV_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter between fetch and data ports
// Data wins ties; a saturating streak counter forces a fetch grant after DATA_STREAK_MAX data grants.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  word_t       iaddr,
    output logic        ihit,
    output word_t       iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        dhit,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic [1:0]  ramstate,
    output logic        bus_err
);

    localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

    arb_state_t state, next_state;
    logic [3:0] streak;
    ramstate_t  ram_st;
    logic       data_req;

    assign ram_st   = ramstate_t'(ramstate);
    assign data_req = dREN | dWEN;
    assign iload    = ramload;
    assign dload    = ramload;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            streak <= 4'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == SERV_D) begin
                if (!iREN)
                    streak <= 4'd0;
                else if (streak != STREAK_MAX)
                    streak <= streak + 4'd1;
            end else if (state == IDLE && next_state == SERV_I) begin
                streak <= 4'd0;
            end
        end
    end

    // A request dropped while being served aborts: strobes fall at once, no hit.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        dhit       = 1'b0;
        bus_err    = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: begin
                if (data_req && (!iREN || streak < STREAK_MAX))
                    next_state = SERV_D;
                else if (iREN)
                    next_state = SERV_I;
            end
            SERV_I: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_st == ACCESS) begin
                        ihit       = 1'b1;
                        next_state = IDLE;
                    end else if (ram_st == ERROR) begin
                        bus_err    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            SERV_D: begin
                if (!data_req) begin
                    next_state = IDLE;
                end else begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ram_st == ACCESS) begin
                        dhit       = 1'b1;
                        next_state = IDLE;
                    end else if (ram_st == ERROR) begin
                        bus_err    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter that shares the single-port RAM between the pipeline's instruction-fetch port (iREN) and data port (dREN/dWEN, as generated by the control unit for LW/SW). It registers one grant at a time and holds the RAM request until the RAM reports ACCESS or ERROR. It returns a one-cycle hit to the winning requester. Data has priority, with a bounded-streak guard so that fetch is never starved. It sits between the pipeline datapath/caches and the RAM model.

## Interface
- DATA_STREAK_MAX, 4, consecutive data grants allowed while iREN is pending before fetch is forced; legal range 1..15.

- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous and active-high.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  32  instruction word address.
- ihit  out  1  instruction read complete this cycle; iload valid.
- iload  out  32  instruction data, a copy of ramload.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit; wins over dREN.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dhit  out  1  data access complete this cycle.
- dload  out  32  read data, a copy of ramload.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- bus_err  out  1  one-cycle pulse when a granted access ends in ERROR.

## Operation
**States**

IDLE, SERV_I, SERV_D.

**IDLE**
- No RAM strobes; ramaddr and ramstore are 0.
- Arbitration:
  - If a data request (dREN|dWEN) is pending and either iREN=0 or streak < DATA_STREAK_MAX, go to SERV_D.
  - Else, if iREN=1, go to SERV_I.
  - Else stay in IDLE.

**SERV_I**
- ramREN = iREN; ramaddr = iaddr.

**SERV_D**
- ramWEN = dWEN.
- ramREN = dREN & ~dWEN.
- ramaddr = daddr; ramstore = dstore.

**Completion (either serving state)**
- ramstate=ACCESS: assert the matching hit combinationally in the same cycle; next state IDLE.
- ramstate=ERROR: assert bus_err, no hit; next state IDLE. The requester still holds its request, so it is re-arbitrated (retry).
- ramstate=BUSY or FREE: stay in the serving state.

**Abort**
- If the served request drops while in a serving state, the RAM strobes drop in the same cycle.
- The next state is IDLE; no hit is asserted.

**Streak counter**
- Width 4 bits, saturating at DATA_STREAK_MAX.
- On a transition IDLE→SERV_D with iREN=1: increment.
- On a transition IDLE→SERV_D with iREN=0: clear to 0.
- On a transition IDLE→SERV_I: clear to 0.

**Reset**
- State goes to IDLE and streak to 0.
- All outputs are 0 during and after reset, except iload/dload, which follow ramload.
- Reset asserted mid-transaction drops the RAM strobes the cycle after the reset edge; no hit is issued.

## Timing
- Minimum latency is 2 cycles from request to hit:
  - Request sampled in IDLE at cycle 0.
  - Strobe driven in cycle 1.
  - Hit in cycle 1 if the RAM returns ACCESS immediately.
- Each additional BUSY cycle adds one cycle.
- Every transaction is followed by one IDLE cycle.
  - Peak throughput is one access per 2 cycles.
- Hit outputs are combinational on ramstate and must not be registered.
- The grant decision is registered; request changes in a serving cycle never switch the grant.
- Requesters change the address only after seeing hit.
- Simultaneous iREN and data request in IDLE: data wins unless streak == DATA_STREAK_MAX.

## Structure
- Add `arb_state_t` (IDLE, SERV_I, SERV_D; 2 bits) to cpu_types_pkg, alongside the existing `ramstate_t`.
- Use the existing `word_t` for the 32-bit buses.
- Single module with no sub-module; the streak counter and FSM are small enough to inline.

## Test plan
- **Reset:** RST=1 for 2 cycles with iREN=dREN=1 → ramREN=ramWEN=0, ihit=dhit=0; first grant occurs 1 cycle after release.
- **Fetch only:** iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C010004 → ihit high in cycle 3 only, iload=0x8C010004.
- **Contention:** iREN=1, dREN=1, daddr=0x100 every cycle, RAM ACCESS immediate → grant pattern D,D,D,D,I repeating with DATA_STREAK_MAX=4; ihit every 10th cycle.
- **Read/write conflict:** dREN=dWEN=1, daddr=0x200, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dhit on ACCESS.
- **RAM error:** ERROR during SERV_D → bus_err pulses 1 cycle, dhit=0; access is re-granted next IDLE and completes with dhit on ACCESS.
- **Abort and mid-transaction reset:** iREN dropped while BUSY → ramREN=0 in the same cycle, IDLE next, no ihit. RST asserted during SERV_D → IDLE after the edge, streak=0.
